// File: rtl/instruction_fetch_unit.sv
// Fetch PC owner and DEPTH-entry in-order instruction queue; grant->decode is 2 cycles.
// Credit-limited issue: queued + outstanding + to-be-dropped responses never exceed DEPTH.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [4:0]  inst_opcode
);
  localparam int          PW  = $clog2(DEPTH);
  localparam int          CW  = PW + 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_word [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] credit_used;
  logic [31:0]   redirect_aligned;
  logic          empty;
  logic          pop;
  logic          push;
  logic          drop;
  logic          grant;
  logic          resp_taken;

  assign empty            = (count == '0);
  assign inst_valid       = !empty && !redirect_valid;
  assign pop              = inst_valid && inst_ready;
  // A slot freed by this cycle's pop is reusable at once, giving one instruction per cycle.
  assign credit_used      = count - {{(CW-1){1'b0}}, pop} + outstanding + discard;
  assign imem_req         = rst_n && !redirect_valid && (credit_used < CW'(DEPTH));
  assign imem_addr        = fetch_pc;
  assign grant            = imem_req && imem_gnt;
  assign resp_taken       = imem_rvalid && ((outstanding != '0) || (discard != '0));
  assign drop             = imem_rvalid && (discard != '0);
  assign push             = imem_rvalid && (discard == '0) && (outstanding != '0) && !redirect_valid;
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

  assign inst        = empty ? NOP : q_word[head];
  assign inst_pc     = empty ? 32'h0 : q_pc[head];
  assign inst_opcode = inst[6:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_aligned;
      resp_pc     <= redirect_aligned;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      // A response landing in the redirect cycle is consumed here, so it is not counted again.
      discard     <= outstanding + discard - {{(CW-1){1'b0}}, resp_taken};
    end else begin
      if (grant) fetch_pc <= fetch_pc + 32'd4;
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
        tail    <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (grant && !push)      outstanding <= outstanding + 1'b1;
      else if (push && !grant) outstanding <= outstanding - 1'b1;
      if (drop) discard <= discard - 1'b1;
    end
  end

  // Responses arrive in order, so resp_pc is always the address of the word being pushed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]   <= resp_pc;
      q_word[tail] <= imem_rdata;
    end
  end
endmodule
